// File: rtl/periph_bus_arbiter_if.sv
// Bundle of the two requester ports plus the register and memory buses.
// The arbiter takes the slave view; the requesters/bus models take the master view.
interface periph_bus_arbiter_if;
  logic        m0_req,     m1_req;
  logic        m0_write,   m1_write;
  logic [31:0] m0_address, m1_address;
  logic [31:0] m0_wdata,   m1_wdata;
  logic        m0_ack,     m1_ack;
  logic        m0_err,     m1_err;
  logic [31:0] m0_rdata,   m1_rdata;

  logic        reg_read, reg_write;
  logic [2:0]  reg_address;
  logic [31:0] reg_data_in;
  logic        reg_read_valid;
  logic [31:0] reg_data_out;

  logic        mem_read, mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_valid;
  logic [31:0] mem_data_out;

  modport master (
    output m0_req, m1_req, m0_write, m1_write, m0_address, m1_address, m0_wdata, m1_wdata,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  reg_read, reg_write, reg_address, reg_data_in,
    output reg_read_valid, reg_data_out,
    input  mem_read, mem_write, mem_address, mem_data_in,
    output mem_read_valid, mem_data_out
  );

  modport slave (
    input  m0_req, m1_req, m0_write, m1_write, m0_address, m1_address, m0_wdata, m1_wdata,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output reg_read, reg_write, reg_address, reg_data_in,
    input  reg_read_valid, reg_data_out,
    output mem_read, mem_write, mem_address, mem_data_in,
    input  mem_read_valid, mem_data_out
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter onto a register bus and a memory bus.
//   state   | meaning
//   IDLE    | waiting for a request; grant and latch on any req
//   ISSUE   | one-cycle strobe to the decoded region (none if unmapped)
//   WAIT_RD | waiting for the selected region's read_valid, with timeout
//   DONE    | one-cycle ack (and err) to the granted requester
module periph_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  periph_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, DONE = 2'd3} state_e;

  localparam logic [1:0]    RGN_NONE = 2'd0;
  localparam logic [1:0]    RGN_REG  = 2'd1;
  localparam logic [1:0]    RGN_MEM  = 2'd2;
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d, last_q, last_d, wr_q, wr_d;
  logic [1:0]    rgn_q, rgn_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic          reg_read_q, reg_read_d, reg_write_q, reg_write_d;
  logic [2:0]    reg_address_q, reg_address_d;
  logic [31:0]   reg_data_in_q, reg_data_in_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [7:0]    mem_address_q, mem_address_d;
  logic [31:0]   mem_data_in_q, mem_data_in_d;
  logic [1:0]    ack_q, ack_d, err_q, err_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          any_req, pick, sel_write, rd_valid, cap_en, unused_addr_bits;
  logic [31:0]   sel_addr, sel_wdata, rd_data, cap_val;
  logic [1:0]    sel_rgn;

  // last_q holds the previous winner; on contention the other requester wins.
  assign any_req   = bus.m0_req | bus.m1_req;
  assign pick      = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
  assign sel_write = pick ? bus.m1_write   : bus.m0_write;
  assign sel_addr  = pick ? bus.m1_address : bus.m0_address;
  assign sel_wdata = pick ? bus.m1_wdata   : bus.m0_wdata;
  assign unused_addr_bits = ^sel_addr[1:0];

  assign sel_rgn = (sel_addr[31:5] == 27'd0)                 ? RGN_REG :
                   (sel_addr[31:11] == 21'd0 && sel_addr[10]) ? RGN_MEM : RGN_NONE;

  assign rd_valid = (rgn_q == RGN_REG) ? bus.reg_read_valid :
                    (rgn_q == RGN_MEM) ? bus.mem_read_valid : 1'b0;
  assign rd_data  = (rgn_q == RGN_REG) ? bus.reg_data_out : bus.mem_data_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      wr_q          <= 1'b0;
      rgn_q         <= RGN_NONE;
      tmr_q         <= '0;
      reg_read_q    <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_address_q <= '0;
      reg_data_in_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      ack_q         <= '0;
      err_q         <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      wr_q          <= wr_d;
      rgn_q         <= rgn_d;
      tmr_q         <= tmr_d;
      reg_read_q    <= reg_read_d;
      reg_write_q   <= reg_write_d;
      reg_address_q <= reg_address_d;
      reg_data_in_q <= reg_data_in_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rgn_d   = rgn_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          gnt_d   = pick;
          last_d  = pick;
          wr_d    = sel_write;
          rgn_d   = sel_rgn;
        end
      end
      ISSUE: begin
        if (!wr_q && rgn_q != RGN_NONE) begin
          state_d = WAIT_RD;
          tmr_d   = TMR_LOAD;
        end else begin
          state_d = DONE;
        end
      end
      WAIT_RD: begin
        if (rd_valid || tmr_q == '0) begin
          state_d = DONE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: each _d is the value for the state being entered.
  always_comb begin
    reg_read_d    = 1'b0;
    reg_write_d   = 1'b0;
    reg_address_d = '0;
    reg_data_in_d = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = '0;
    mem_data_in_d = '0;
    ack_d         = '0;
    err_d         = '0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    cap_en        = 1'b0;
    cap_val       = '0;
    case (state_q)
      IDLE: begin
        if (any_req && sel_rgn == RGN_REG) begin
          reg_read_d    = ~sel_write;
          reg_write_d   = sel_write;
          reg_address_d = sel_addr[4:2];
          reg_data_in_d = sel_write ? sel_wdata : '0;
        end
        if (any_req && sel_rgn == RGN_MEM) begin
          mem_read_d    = ~sel_write;
          mem_write_d   = sel_write;
          mem_address_d = sel_addr[9:2];
          mem_data_in_d = sel_write ? sel_wdata : '0;
        end
      end
      ISSUE: begin
        if (wr_q || rgn_q == RGN_NONE) begin
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = (rgn_q == RGN_NONE);
          cap_en       = ~wr_q;
        end
      end
      WAIT_RD: begin
        if (rd_valid) begin
          ack_d[gnt_q] = 1'b1;
          cap_en       = 1'b1;
          cap_val      = rd_data;
        end else if (tmr_q == '0) begin
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          cap_en       = 1'b1;
        end
      end
      default: ;
    endcase
    if (cap_en) begin
      if (gnt_q) rdata1_d = cap_val;
      else       rdata0_d = cap_val;
    end
  end

  assign bus.reg_read    = reg_read_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.reg_address = reg_address_q;
  assign bus.reg_data_in = reg_data_in_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.m0_ack      = ack_q[0];
  assign bus.m1_ack      = ack_q[1];
  assign bus.m0_err      = err_q[0];
  assign bus.m1_err      = err_q[1];
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: table of single transactions plus hand-written
// round-robin and reset-abort sequences, with acks checked against a queue.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  periph_bus_arbiter_if bus();
  periph_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // cycles after strobe to read_valid; -1 none, 0 n/a
    logic [31:0] rd_ret;
    bit          stray;
    logic [3:0]  exp_stb; // {reg_read, reg_write, mem_read, mem_write}
    logic [7:0]  exp_baddr;
    logic [31:0] exp_bdata;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          m;
    bit          err;
    logic [31:0] rdata;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vecs[10];
  logic [31:0] rd_model[2];
  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;

  function automatic vec_t mk(bit m, bit wr, logic [31:0] addr, logic [31:0] wdata, int delay,
                              logic [31:0] rd_ret, bit stray, logic [3:0] stb, logic [7:0] baddr,
                              logic [31:0] bdata, bit err, logic [31:0] exp_rd, int lat);
    vec_t v;
    v.m = m; v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay; v.rd_ret = rd_ret;
    v.stray = stray; v.exp_stb = stb; v.exp_baddr = baddr; v.exp_bdata = bdata;
    v.exp_err = err; v.exp_rd = exp_rd; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [159:0] got, logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] stb();
    return {bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write};
  endfunction

  function automatic logic [159:0] all_outputs();
    return {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata,
            bus.reg_read, bus.reg_write, bus.reg_address, bus.reg_data_in,
            bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_data_in};
  endfunction

  // Every bench wait goes through here so acks and strobes are always watched.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (bus.m0_ack || bus.m1_ack) begin
      ack_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack m0_ack=%0b m1_ack=%0b", bus.m0_ack, bus.m1_ack);
      end else begin
        e = sbq.pop_front();
        check("ack_master", {bus.m0_ack, bus.m1_ack}, e.m ? 2'b01 : 2'b10);
        check("ack_err", e.m ? bus.m1_err : bus.m0_err, e.err);
        check("ack_rdata", e.m ? bus.m1_rdata : bus.m0_rdata, e.rdata);
      end
    end
    if (|stb()) check("single_strobe", $countones(stb()), 1);
  endtask

  task automatic set_master(bit m, bit req, bit wr, logic [31:0] a, logic [31:0] d);
    if (m) begin
      bus.m1_req = req; bus.m1_write = wr; bus.m1_address = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = req; bus.m0_write = wr; bus.m0_address = a; bus.m0_wdata = d;
    end
  endtask

  task automatic push_exp(bit m, bit err, logic [31:0] rd, bit is_read);
    sb_t e;
    if (is_read) rd_model[m] = rd;
    e.m = m; e.err = err; e.rdata = rd_model[m];
    sbq.push_back(e);
  endtask

  task automatic run_txn(vec_t v);
    int lat = 0;
    bit done = 0;
    push_exp(v.m, v.exp_err, v.exp_rd, !v.wr);
    set_master(v.m, 1'b1, v.wr, v.addr, v.wdata);
    while (!done && lat < 40) begin
      tick();
      lat++;
      bus.reg_read_valid = 1'b0;
      bus.mem_read_valid = 1'b0;
      if (bus.m0_ack || bus.m1_ack) begin
        check("latency", lat, v.exp_lat);
        done = 1;
      end
      if (lat == 1) begin
        check("strobe", stb(), v.exp_stb);
        if (v.exp_stb[3] || v.exp_stb[2]) check("reg_address", bus.reg_address, v.exp_baddr[2:0]);
        if (v.exp_stb[1] || v.exp_stb[0]) check("mem_address", bus.mem_address, v.exp_baddr);
        if (v.exp_stb[2]) check("reg_data_in", bus.reg_data_in, v.exp_bdata);
        if (v.exp_stb[0]) check("mem_data_in", bus.mem_data_in, v.exp_bdata);
        // Drop the request and scramble the fields; the granted copy must hold.
        set_master(v.m, 1'b0, ~v.wr, 32'hFFFF_FFFC, 32'h5A5A_0000);
      end
      if (lat == 2) check("strobe_one_cycle", stb(), 4'b0000);
      if (v.stray && lat == 3) begin
        if (v.exp_stb[3]) begin bus.mem_read_valid = 1'b1; bus.mem_data_out = 32'hBAD0_BAD0; end
        else              begin bus.reg_read_valid = 1'b1; bus.reg_data_out = 32'hBAD0_BAD0; end
      end
      if (v.delay > 0 && lat == 1 + v.delay) begin
        if (v.exp_stb[3]) begin bus.reg_read_valid = 1'b1; bus.reg_data_out = v.rd_ret; end
        else              begin bus.mem_read_valid = 1'b1; bus.mem_data_out = v.rd_ret; end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout waited=%0d cycles exp_latency=%0d", lat, v.exp_lat);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    vecs[0] = mk(0, 1, 32'h400, 32'hA5A5_A5A5, 0, 0, 0, 4'b0001, 8'h00, 32'hA5A5_A5A5, 0, 0, 2);
    vecs[1] = mk(1, 0, 32'h10,  0, 2,  32'h1234,      0, 4'b1000, 8'h04, 0, 0, 32'h1234, 4);
    vecs[2] = mk(0, 0, 32'h200, 0, 0,  0,             0, 4'b0000, 8'h00, 0, 1, 0, 2);
    vecs[3] = mk(1, 0, 32'h7FC, 0, -1, 0,             1, 4'b0010, 8'hFF, 0, 1, 0, TO + 2);
    vecs[4] = mk(0, 1, 32'h1C,  32'hDEAD_BEEF, 0, 0, 0, 4'b0100, 8'h07, 32'hDEAD_BEEF, 0, 0, 2);
    vecs[5] = mk(0, 0, 32'h1F,  0, 1,  32'hCAFE_F00D, 0, 4'b1000, 8'h07, 0, 0, 32'hCAFE_F00D, 3);
    vecs[6] = mk(1, 0, 32'h800, 0, 0,  0,             0, 4'b0000, 8'h00, 0, 1, 0, 2);
    vecs[7] = mk(1, 0, 32'h400, 0, TO, 32'h55AA,      1, 4'b0010, 8'h00, 0, 0, 32'h55AA, TO + 2);
    vecs[8] = mk(0, 1, 32'h20,  32'h99, 0, 0,         0, 4'b0000, 8'h00, 0, 1, 0, 2);
    vecs[9] = mk(1, 1, 32'h7FC, 32'h0BAD_F00D, 0, 0, 0, 4'b0001, 8'hFF, 32'h0BAD_F00D, 0, 0, 2);

    rd_model[0] = '0;
    rd_model[1] = '0;
    set_master(0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0);
    bus.reg_read_valid = 1'b0; bus.reg_data_out = '0;
    bus.mem_read_valid = 1'b0; bus.mem_data_out = '0;

    reset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outputs(), '0);
    reset = 1'b1;
    tick();

    // Both requesters hold req: grants alternate starting with m0.
    push_exp(0, 0, 0, 0);
    push_exp(1, 0, 0, 0);
    push_exp(0, 0, 0, 0);
    push_exp(1, 0, 0, 0);
    set_master(0, 1, 1, 32'h400, 32'h1111_1111);
    set_master(1, 1, 1, 32'h404, 32'h2222_2222);
    base = ack_cnt;
    n = 0;
    while (ack_cnt - base < 4 && n < 60) begin
      tick();
      n++;
      if (bus.mem_write) check("rr_mem_data", bus.mem_data_in,
                               (bus.mem_address == 8'h01) ? 32'h2222_2222 : 32'h1111_1111);
    end
    set_master(0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0);
    tick();
    check("rr_all_acked", sbq.size(), 0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while m0 waits on a register read: no ack, late valid ignored.
    set_master(0, 1, 0, 32'h10, 0);
    tick();
    check("abort_strobe", stb(), 4'b1000);
    set_master(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    check("abort_outputs", all_outputs(), '0);
    rd_model[0] = '0;
    rd_model[1] = '0;
    reset = 1'b1;
    base = ack_cnt;
    bus.reg_read_valid = 1'b1;
    bus.reg_data_out = 32'h7777_7777;
    tick();
    bus.reg_read_valid = 1'b0;
    repeat (4) tick();
    check("abort_no_ack", ack_cnt - base, 0);
    run_txn(mk(0, 1, 32'h404, 32'h1357_9BDF, 0, 0, 0, 4'b0001, 8'h01, 32'h1357_9BDF, 0, 0, 2));
    check("queue_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles waiting for read_valid before error completion.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 m0_req, m1_req  in  1  requester transaction request.
REQ-005 m0_write, m1_write  in  1  1 = write, 0 = read.
REQ-006 m0_address, m1_address  in  32  byte address.
REQ-007 m0_wdata, m1_wdata  in  32  write data.
REQ-008 m0_ack, m1_ack  out  1  one-cycle completion pulse.
REQ-009 m0_err, m1_err  out  1  error qualifier, valid only with ack.
REQ-010 m0_rdata, m1_rdata  out  32  read data, valid with ack.
REQ-011 reg_read, reg_write  out  1  register-bus strobes.
REQ-012 reg_address  out  3  word index, address[4:2].
REQ-013 reg_data_in  out  32  register write data.
REQ-014 reg_read_valid  in  1; reg_data_out  in  32  register read return.
REQ-015 mem_read, mem_write  out  1  memory-bus strobes.
REQ-016 mem_address  out  8  word index, address[9:2].
REQ-017 mem_data_in  out  32  memory write data.
REQ-018 mem_read_valid  in  1; mem_data_out  in  32  memory read return.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT_RD, DONE; all outputs registered.
REQ-020 IDLE: if any req, grant, latch granted master's write/address/wdata, go ISSUE; else stay.
REQ-021 Arbitration round-robin: both req -> grant master not granted last; single req -> grant it.
REQ-022 Decode latched address: 0..31 -> register region; 1024..2047 -> memory region; else unmapped; address[1:0] ignored.
REQ-023 ISSUE lasts exactly one cycle: exactly one strobe (reg_/mem_ read/write per region and direction) high, address/data driven; unmapped -> no strobe.
REQ-024 ISSUE -> DONE for writes and unmapped; ISSUE -> WAIT_RD for mapped reads.
REQ-025 WAIT_RD: only the selected region's read_valid counts; on valid capture its data_out into rdata, go DONE; other region's valid ignored.
REQ-026 WAIT_RD timeout: TIMEOUT_CYCLES cycles without valid -> DONE with err=1, rdata=0.
REQ-027 DONE: granted master's ack=1 for exactly one cycle; err=1 for unmapped or timeout, else 0; go IDLE.
REQ-028 Write latency: req sampled in IDLE at edge N -> strobe in cycle N+1 -> ack in cycle N+2.
REQ-029 Read latency: ack one cycle after read_valid sampled.
REQ-030 Latched fields are frozen from grant to ack; requester changes during that window ignored.
REQ-031 Non-granted requester waits; its req may stay high; no ack issued to it.
REQ-032 Requester deasserts req in ack cycle; req still high in ack cycle is treated as a new request, arbitrated in the following IDLE cycle.
REQ-033 One IDLE cycle minimum between transactions; at most one transaction outstanding.
REQ-034 rdata holds last captured value until next read completion to that master; writes leave it unchanged.

Reset
REQ-035 reset=0 at rising edge: state IDLE, all strobes, acks, errs 0, rdata/address/data outputs 0, timeout counter 0, last-grant = m1, so m0 wins first contention.
REQ-036 Reset mid-transaction aborts it: no ack issued; late read_valid after reset ignored.

Verification
REQ-037 m0 write 0x400 data 0xA5A5A5A5 -> mem_write high one cycle, mem_address=0x00, mem_data_in=0xA5A5A5A5, m0_ack two cycles after req, err=0.
REQ-038 m1 read 0x10, reg_read_valid with reg_data_out=0x1234 two cycles after strobe -> reg_address=4, m1_rdata=0x1234, m1_ack next cycle.
REQ-039 m0 and m1 both hold req for 4 transactions -> grants alternate m0,m1,m0,m1; no simultaneous strobes.
REQ-040 m0 read 0x200 (unmapped) -> no strobes, m0_ack with m0_err=1, rdata=0.
REQ-041 m1 read 0x7FC with no mem_read_valid -> m1_ack with err=1 after 16 WAIT_RD cycles; stray reg_read_valid during wait ignored.
REQ-042 reset asserted during WAIT_RD -> all outputs 0 next cycle, no ack; subsequent m0 write completes normally.
